fft_frame_ctrl: RTL and testbench

Frame sequencer and flow controller for the stage-0 FFT datapath (butterfly x3 + CBFP, 16 complex lanes per block, 32 blocks per 512-point frame).
- Input side: grants a valid/ready source, generates the datapath's valid_in and the input block index, and checks frame alignment against src_last.
- Output side: tracks blocks in flight through the non-stallable pipeline and caps them so the downstream buffers cannot overflow.
- Output tagging: marks each returning block with its block index and frame boundary.
- Data buses bypass this block; it handles control only.

---
 rtl/fft_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer and flow controller for the stage-0 FFT datapath.
// Grants source blocks, caps blocks in flight and tags returning blocks.
module fft_frame_ctrl #(
  parameter int BLK_PER_FRAME = 32,
  parameter int MAX_INFLIGHT  = 48,
  parameter int CNT_W         = 6,
  parameter int FRM_W         = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [FRM_W-1:0]                 num_frames,
  input  logic                             src_valid,
  input  logic                             src_last,
  output logic                             src_ready,
  output logic                             fft_valid_in,
  output logic [$clog2(BLK_PER_FRAME)-1:0] in_blk_idx,
  input  logic                             fft_valid_out,
  output logic [$clog2(BLK_PER_FRAME)-1:0] out_blk_idx,
  output logic                             out_frame_last,
  output logic [CNT_W-1:0]                 inflight,
  output logic                             busy,
  output logic                             done,
  output logic                             err_framing,
  output logic                             err_underflow
);

  localparam int                BLK_W    = $clog2(BLK_PER_FRAME);
  localparam logic [BLK_W-1:0]  LAST_BLK = BLK_W'(BLK_PER_FRAME - 1);
  localparam logic [CNT_W-1:0]  MAX_CNT  = CNT_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [FRM_W-1:0]   nframes_q, nframes_d;
  logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BLK_W-1:0]   in_blk_q, in_blk_d;
  logic [BLK_W-1:0]   out_blk_q, out_blk_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               err_framing_q, err_framing_d;
  logic               err_underflow_q, err_underflow_d;
  logic               accept;
  logic               blk_end;
  logic               frame_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      nframes_q       <= '0;
      frame_cnt_q     <= '0;
      in_blk_q        <= '0;
      out_blk_q       <= '0;
      inflight_q      <= '0;
      err_framing_q   <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      nframes_q       <= nframes_d;
      frame_cnt_q     <= frame_cnt_d;
      in_blk_q        <= in_blk_d;
      out_blk_q       <= out_blk_d;
      inflight_q      <= inflight_d;
      err_framing_q   <= err_framing_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    nframes_d       = nframes_q;
    frame_cnt_d     = frame_cnt_q;
    in_blk_d        = in_blk_q;
    out_blk_d       = out_blk_q;
    inflight_d      = inflight_q;
    err_framing_d   = err_framing_q;
    err_underflow_d = err_underflow_q;

    src_ready = (state_q == S_RUN) && (inflight_q < MAX_CNT);
    accept    = src_valid & src_ready;
    blk_end   = (in_blk_q == LAST_BLK);
    // A frame ends on either a last-block index or src_last; disagreement flags framing.
    frame_end = accept & (blk_end | src_last);

    if (accept && !fft_valid_out) begin
      inflight_d = inflight_q + 1'b1;
    end else if (fft_valid_out && !accept) begin
      if (inflight_q == '0) begin
        err_underflow_d = 1'b1;
      end else begin
        inflight_d = inflight_q - 1'b1;
      end
    end

    if (fft_valid_out) begin
      out_blk_d = (out_blk_q == LAST_BLK) ? '0 : out_blk_q + 1'b1;
    end

    if (accept) begin
      in_blk_d = frame_end ? '0 : in_blk_q + 1'b1;
      if (src_last != blk_end) begin
        err_framing_d = 1'b1;
      end
    end

    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nframes_d       = num_frames;
          frame_cnt_d     = '0;
          in_blk_d        = '0;
          out_blk_d       = '0;
          err_framing_d   = 1'b0;
          err_underflow_d = 1'b0;
          state_d         = S_RUN;
        end
      end
      S_RUN: begin
        if (abort ||
            (frame_end && (nframes_q != '0) && (frame_cnt_q + 1'b1 == nframes_q))) begin
          state_d = S_DRAIN;
        end
      end
      // No accepts while draining, so the next-state count already reflects any return.
      S_DRAIN: begin
        if (inflight_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fft_valid_in   = accept;
  assign in_blk_idx     = in_blk_q;
  assign out_blk_idx    = out_blk_q;
  assign out_frame_last = fft_valid_out & (out_blk_q == LAST_BLK);
  assign inflight       = inflight_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign err_framing    = err_framing_q;
  assign err_underflow  = err_underflow_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl: 10-cycle pipeline model plus
// an in-order scoreboard of expected return tags.
module tb_fft_frame_ctrl;

  localparam int DLY = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_frames = '0;
  logic       src_valid = 1'b0;
  logic       src_last = 1'b0;
  logic       src_ready;
  logic       fft_valid_in;
  logic [4:0] in_blk_idx;
  logic       fft_valid_out;
  logic [4:0] out_blk_idx;
  logic       out_frame_last;
  logic [5:0] inflight;
  logic       busy;
  logic       done;
  logic       err_framing;
  logic       err_underflow;

  logic           pipe_en = 1'b0;
  logic           ret_force = 1'b0;
  logic [DLY-1:0] dl;

  int checks = 0;
  int errors = 0;

  int sb_q[$];
  int tag_cnt = 0;
  int exp_in = 0;

  fft_frame_ctrl #(
    .BLK_PER_FRAME(32),
    .MAX_INFLIGHT (48),
    .CNT_W        (6),
    .FRM_W        (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .num_frames    (num_frames),
    .src_valid     (src_valid),
    .src_last      (src_last),
    .src_ready     (src_ready),
    .fft_valid_in  (fft_valid_in),
    .in_blk_idx    (in_blk_idx),
    .fft_valid_out (fft_valid_out),
    .out_blk_idx   (out_blk_idx),
    .out_frame_last(out_frame_last),
    .inflight      (inflight),
    .busy          (busy),
    .done          (done),
    .err_framing   (err_framing),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Datapath model: fixed-latency, non-stallable.
  always @(posedge clk or posedge rst) begin
    if (rst) dl <= '0;
    else     dl <= {dl[DLY-2:0], fft_valid_in & pipe_en};
  end
  assign fft_valid_out = dl[DLY-1] | ret_force;

  // Scoreboard: tag pushed on accept, popped and compared on return.
  always @(negedge clk) begin : mon
    int t;
    if (rst) begin
      sb_q.delete();
      tag_cnt = 0;
      exp_in  = 0;
    end else begin
      if (fft_valid_out && sb_q.size() > 0) begin
        t = sb_q.pop_front();
        checks++;
        if (out_blk_idx !== t[4:0]) begin
          errors++;
          $display("FAIL sb_out_blk_idx got %0d want %0d", out_blk_idx, t);
        end
        checks++;
        if (out_frame_last !== (t == 31)) begin
          errors++;
          $display("FAIL sb_out_frame_last got %b want %b tag %0d", out_frame_last, (t == 31), t);
        end
      end
      if (fft_valid_in) begin
        checks++;
        if (in_blk_idx !== exp_in[4:0]) begin
          errors++;
          $display("FAIL sb_in_blk_idx got %0d want %0d", in_blk_idx, exp_in);
        end
        sb_q.push_back(tag_cnt);
        tag_cnt = (tag_cnt + 1) % 32;
        exp_in  = (src_last || exp_in == 31) ? 0 : exp_in + 1;
      end
      if (start) begin
        sb_q.delete();
        tag_cnt = 0;
        exp_in  = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] nf);
    num_frames = nf;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({src_ready, fft_valid_in, done, err_framing, err_underflow, busy, out_frame_last} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {src_ready, fft_valid_in, done, err_framing, err_underflow, busy, out_frame_last});
    end
    checks++;
    if (in_blk_idx !== 5'd0) begin errors++; $display("FAIL reset_in_blk got %0d want 0", in_blk_idx); end
    checks++;
    if (out_blk_idx !== 5'd0) begin errors++; $display("FAIL reset_out_blk got %0d want 0", out_blk_idx); end
    checks++;
    if (inflight !== 6'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_underflow();
    bit seen;
    pipe_en = 1'b0;
    ret_force = 1'b1;
    next_cycle();
    ret_force = 1'b0;
    #1;
    checks++;
    if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b want 1", err_underflow); end
    checks++;
    if (inflight !== 6'd0) begin errors++; $display("FAIL uf_inflight got %0d want 0", inflight); end
    checks++;
    if (out_blk_idx !== 5'd1) begin errors++; $display("FAIL uf_out_blk got %0d want 1", out_blk_idx); end
    next_cycle();
    pulse_start(8'd1);
    #1;
    checks++;
    if (err_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", err_underflow); end
    checks++;
    if (out_blk_idx !== 5'd0) begin errors++; $display("FAIL uf_out_blk_clear got %0d want 0", out_blk_idx); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL uf_busy got %b want 1", busy); end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (done) seen = 1;
      next_cycle();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL uf_done got 0 want 1"); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL uf_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_single_frame();
    int n, peak, lastret, donecyc, flast, flast_idx, dones, rdy_after, rets;
    pipe_en = 1'b1;
    pulse_start(8'd1);
    src_valid = 1'b1;
    n = 0; peak = 0; lastret = -1; donecyc = -100; flast = 0; flast_idx = -1;
    dones = 0; rdy_after = 0; rets = 0;
    for (int c = 0; c < 80; c++) begin
      src_last = (n == 31);
      #1;
      if (n >= 32 && src_ready) rdy_after++;
      if (fft_valid_in) n++;
      if (out_frame_last) begin flast++; flast_idx = int'(out_blk_idx); end
      if (fft_valid_out) begin lastret = c; rets++; end
      if (done) begin dones++; donecyc = c; end
      if (int'(inflight) > peak) peak = int'(inflight);
      next_cycle();
    end
    src_valid = 1'b0;
    src_last = 1'b0;
    checks++;
    if (n != 32) begin errors++; $display("FAIL sf_accepts got %0d want 32", n); end
    checks++;
    if (rdy_after != 0) begin errors++; $display("FAIL sf_ready_after got %0d want 0", rdy_after); end
    checks++;
    if (rets != 32) begin errors++; $display("FAIL sf_returns got %0d want 32", rets); end
    checks++;
    if (flast != 1 || flast_idx != 31) begin
      errors++; $display("FAIL sf_frame_last got count %0d idx %0d want 1 idx 31", flast, flast_idx);
    end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL sf_done_pulses got %0d want 1", dones); end
    checks++;
    if (donecyc != lastret + 1) begin
      errors++; $display("FAIL sf_done_timing got cycle %0d want %0d", donecyc, lastret + 1);
    end
    checks++;
    if (peak != 10) begin errors++; $display("FAIL sf_peak got %0d want 10", peak); end
    checks++;
    if (inflight !== 6'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL sf_end got inflight %0d busy %b want 0 0", inflight, busy);
    end
  endtask

  task automatic test_backpressure();
    int n, m;
    bit seen;
    pipe_en = 1'b0;
    pulse_start(8'd0);
    src_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 60; c++) begin
      src_last = (n % 32 == 31);
      #1;
      if (fft_valid_in) n++;
      next_cycle();
    end
    src_last = (n % 32 == 31);
    #1;
    checks++;
    if (n != 48) begin errors++; $display("FAIL bp_accepts got %0d want 48", n); end
    checks++;
    if (src_ready !== 1'b0 || inflight !== 6'd48) begin
      errors++; $display("FAIL bp_cap got ready %b inflight %0d want 0 48", src_ready, inflight);
    end
    ret_force = 1'b1;
    next_cycle();
    ret_force = 1'b0;
    m = 0;
    for (int c = 0; c < 10; c++) begin
      src_last = (n % 32 == 31);
      #1;
      if (fft_valid_in) begin m++; n++; end
      next_cycle();
    end
    checks++;
    if (m != 1) begin errors++; $display("FAIL bp_one_more got %0d want 1", m); end
    checks++;
    if (inflight !== 6'd48) begin errors++; $display("FAIL bp_refill got %0d want 48", inflight); end
    ret_force = 1'b1;
    m = 0;
    for (int c = 0; c < 2; c++) begin
      src_last = (n % 32 == 31);
      #1;
      if (fft_valid_in) begin m++; n++; end
      next_cycle();
    end
    ret_force = 1'b0;
    #1;
    checks++;
    if (m != 1 || inflight !== 6'd47) begin
      errors++; $display("FAIL bp_simul got accepts %0d inflight %0d want 1 47", m, inflight);
    end
    src_last = (n % 32 == 31);
    next_cycle();
    #1;
    checks++;
    if (inflight !== 6'd48 || src_ready !== 1'b0) begin
      errors++; $display("FAIL bp_recap got inflight %0d ready %b want 48 0", inflight, src_ready);
    end
    src_valid = 1'b0;
    src_last = 1'b0;
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      ret_force = (inflight != 6'd0);
      #1;
      if (done) seen = 1;
      next_cycle();
    end
    ret_force = 1'b0;
    checks++;
    if (!seen || busy !== 1'b0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL bp_drain got done %b busy %b uf %b want 1 0 0", seen, busy, err_underflow);
    end
  endtask

  task automatic test_framing();
    int n, errb4, idx_after;
    bit seen;
    pipe_en = 1'b1;
    pulse_start(8'd2);
    src_valid = 1'b1;
    n = 0; errb4 = -1; idx_after = -1; seen = 0;
    for (int c = 0; c < 150 && !seen; c++) begin
      src_last = (n == 20 || n == 52);
      #1;
      if (fft_valid_in) begin
        if (n == 20) errb4 = int'(err_framing);
        if (n == 21) idx_after = int'(in_blk_idx);
        n++;
      end
      if (done) seen = 1;
      next_cycle();
    end
    src_valid = 1'b0;
    src_last = 1'b0;
    checks++;
    if (errb4 != 0) begin errors++; $display("FAIL fr_early_err_before got %0d want 0", errb4); end
    checks++;
    if (err_framing !== 1'b1) begin errors++; $display("FAIL fr_early_err got %b want 1", err_framing); end
    checks++;
    if (idx_after != 0) begin errors++; $display("FAIL fr_early_restart got %0d want 0", idx_after); end
    checks++;
    if (n != 53 || !seen) begin errors++; $display("FAIL fr_early_frames got %0d done %b want 53 1", n, seen); end

    pulse_start(8'd2);
    #1;
    checks++;
    if (err_framing !== 1'b0) begin errors++; $display("FAIL fr_start_clear got %b want 0", err_framing); end
    src_valid = 1'b1;
    src_last = 1'b0;
    n = 0; errb4 = -1; idx_after = -1; seen = 0;
    for (int c = 0; c < 150 && !seen; c++) begin
      #1;
      if (fft_valid_in) begin
        if (n == 31) errb4 = int'(err_framing);
        if (n == 32) idx_after = int'(in_blk_idx);
        n++;
      end
      if (done) seen = 1;
      next_cycle();
    end
    src_valid = 1'b0;
    checks++;
    if (errb4 != 0 || err_framing !== 1'b1) begin
      errors++; $display("FAIL fr_nolast_err got before %0d after %b want 0 1", errb4, err_framing);
    end
    checks++;
    if (idx_after != 0) begin errors++; $display("FAIL fr_nolast_wrap got %0d want 0", idx_after); end
    checks++;
    if (n != 64 || !seen) begin errors++; $display("FAIL fr_nolast_frames got %0d done %b want 64 1", n, seen); end
  endtask

  task automatic test_abort();
    int n, rets, rets_at_done, rdy_after;
    bit seen, aborted;
    pipe_en = 1'b1;
    pulse_start(8'd0);
    src_valid = 1'b1;
    n = 0; rets = 0; rets_at_done = -1; rdy_after = 0; seen = 0; aborted = 0;
    for (int c = 0; c < 150 && !seen; c++) begin
      src_last = (n % 32 == 31);
      abort = (n == 39) && !aborted;
      #1;
      if (aborted && src_ready) rdy_after++;
      if (fft_valid_in) n++;
      if (done) begin seen = 1; rets_at_done = rets; end
      if (fft_valid_out) rets++;
      if (abort) aborted = 1;
      next_cycle();
    end
    abort = 1'b0;
    src_valid = 1'b0;
    src_last = 1'b0;
    checks++;
    if (n != 40) begin errors++; $display("FAIL ab_accepts got %0d want 40", n); end
    checks++;
    if (rdy_after != 0) begin errors++; $display("FAIL ab_ready_after got %0d want 0", rdy_after); end
    checks++;
    if (!seen || rets_at_done != 40) begin
      errors++; $display("FAIL ab_done got done %b returns %0d want 1 40", seen, rets_at_done);
    end
    checks++;
    if (out_blk_idx !== 5'd8 || inflight !== 6'd0) begin
      errors++; $display("FAIL ab_end got out_blk %0d inflight %0d want 8 0", out_blk_idx, inflight);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    bit hit, seen;
    pipe_en = 1'b1;
    pulse_start(8'd0);
    src_valid = 1'b1;
    src_last = 1'b0;
    hit = 0;
    for (int c = 0; c < 40 && !hit; c++) begin
      #1;
      if (fft_valid_in && in_blk_idx == 5'd17) hit = 1;
      else next_cycle();
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (!hit) begin errors++; $display("FAIL rm_reach17 got 0 want 1"); end
    checks++;
    if ({src_ready, fft_valid_in, busy, done, out_frame_last, err_framing, err_underflow} !== 7'b0) begin
      errors++;
      $display("FAIL rm_async_flags got %b want 0000000",
               {src_ready, fft_valid_in, busy, done, out_frame_last, err_framing, err_underflow});
    end
    checks++;
    if (in_blk_idx !== 5'd0 || out_blk_idx !== 5'd0 || inflight !== 6'd0) begin
      errors++; $display("FAIL rm_async_cnt got in %0d out %0d infl %0d want 0 0 0",
                         in_blk_idx, out_blk_idx, inflight);
    end
    #4;
    rst = 1'b0;
    src_valid = 1'b0;
    next_cycle();
    pulse_start(8'd2);
    src_valid = 1'b1;
    n = 0; seen = 0;
    for (int c = 0; c < 150 && !seen; c++) begin
      src_last = (n % 32 == 31);
      #1;
      if (fft_valid_in) n++;
      if (done) seen = 1;
      next_cycle();
    end
    src_valid = 1'b0;
    src_last = 1'b0;
    checks++;
    if (n != 64 || !seen) begin errors++; $display("FAIL rm_rerun got %0d done %b want 64 1", n, seen); end
    checks++;
    if (err_framing !== 1'b0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL rm_rerun_err got %b %b want 0 0", err_framing, err_underflow);
    end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_single_frame();
    test_backpressure();
    test_framing();
    test_abort();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

endmodule
